sram_req_arbiter: RTL and testbench
===================================

Name: sram_req_arbiter

Overview:
- Sequences all accesses to the 1024x8 single-port SRAM macro (din/dout/sense_en/wen/addr interface) and shares it between two requesters, for example a cache lookup port and a line-fill/writeback port.
- Arbitrates round-robin and accepts one operation at a time over a valid/ready handshake.
- Drives registered SRAM control strobes, waits out the SRAM read latency, then returns read data or a write acknowledge to the requester that issued the operation.

Parameters:
- SRAM_LATENCY, 1: cycles from the SRAM sense edge to valid dout. Legal range 1..15.
- ADDR_W, 10: SRAM address width.
- DATA_W, 8: SRAM data width.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept; at most one bit high.
- req_we  input  2  per-requester op select: 1 = write, 0 = read.
- req_addr  input  2*ADDR_W  requester i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  input  2*DATA_W  requester i at bits [i*DATA_W +: DATA_W].
- rsp_valid  output  2  one-cycle completion pulse to the owning requester.
- rsp_rdata  output  DATA_W  read data, valid only while a rsp_valid bit is high.
- sram_wen  output  1  to SRAM wen.
- sram_sense_en  output  1  to SRAM sense_en.
- sram_addr  output  ADDR_W  to SRAM addr.
- sram_din  output  DATA_W  to SRAM din.
- sram_dout  input  DATA_W  from SRAM dout.

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, round-robin pointer last_gnt = 1 (requester 0 wins first), wait counter 0. Reset mid-operation aborts the operation; no rsp_valid is ever issued for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is combinational: the grant goes to the valid requester; if both are valid, to the one != last_gnt.
  - On handshake (req_valid[g] & req_ready[g]): latch g, we, addr, wdata; set last_gnt = g; go to ISSUE.
- ISSUE (exactly one cycle):
  - sram_addr = latched addr.
  - Write: sram_wen = 1, sram_sense_en = 0, sram_din = wdata.
  - Read: sram_sense_en = 1, sram_wen = 0.
  - Strobes come from registers and are high only in this cycle.
  - Next state: write -> RESP; read -> WAIT with counter = SRAM_LATENCY.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture sram_dout into rsp_rdata at that edge and go to RESP.
  - Result: with ISSUE in cycle I, data is sampled at the end of cycle I+SRAM_LATENCY.
- RESP (one cycle):
  - rsp_valid[g] = 1, then go to IDLE.
  - Write completion: rsp_rdata holds its previous value.
- req_ready is 0 in every state other than IDLE. There is never more than one outstanding op.
- Latencies, counted from the accept cycle A:
  - Write: rsp_valid in A+2; next accept possible in A+3.
  - Read: rsp_valid in A+SRAM_LATENCY+2; next accept possible in A+SRAM_LATENCY+3.
- sram_addr and sram_din hold their last value outside ISSUE. Addresses are not modified and do not wrap.
- A request that drops valid before it is accepted is never issued.
- Simultaneous requests are resolved only by the round-robin pointer. The we value plays no part in arbitration.

Optional Feature:
- Macro: SRAM_REQ_ARBITER_STATS_EN.
- Defined:
  - Adds outputs stat_rd_cnt and stat_wr_cnt, each 16 bits.
  - They count completed reads and writes, incrementing in the RESP cycle.
  - They saturate at 16'hFFFF and are cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle; rst pulsed asynchronously mid-cycle -> all outputs 0 immediately; req_ready = 2'b01 when only req0 is valid.
- Single write, req0 (we=1, addr=10'h155, wdata=8'hA5) -> sram_wen = 1 with addr 10'h155 and din 8'hA5 one cycle after accept; rsp_valid = 2'b01 in the following cycle.
- Read-back, SRAM_LATENCY = 1 and 3; req1 reads 10'h155 -> sram_sense_en pulses once; rsp_valid = 2'b10 with rsp_rdata = 8'hA5 at A+3 (latency 1) and A+5 (latency 3).
- Both requesters held valid continuously for 6 ops -> grants alternate 0,1,0,1,0,1; exactly one req_ready bit is high per accept.
- rst asserted during WAIT of a read -> no rsp_valid is produced; after release the next request completes normally with the correct data.
- With SRAM_REQ_ARBITER_STATS_EN defined: 3 writes and 2 reads -> stat_wr_cnt = 3, stat_rd_cnt = 2.

Source files
------------

// File: rtl/sram_req_arbiter_if.sv
// rtl/sram_req_arbiter_if.sv - requester and SRAM-macro signal bundle for sram_req_arbiter
//
// Purpose: groups the two-requester valid/ready request channel, the response
// channel and the single-port SRAM macro pins into one bundle.
// Modports:
//   master - environment side: drives requests and sram_dout, observes the rest
//   slave  - arbiter side: accepts requests, drives responses and SRAM strobes
// Signals:
//   req_valid/req_ready/req_we [1:0], req_addr [2*ADDR_W], req_wdata [2*DATA_W]
//   rsp_valid [1:0], rsp_rdata [DATA_W]
//   sram_wen, sram_sense_en, sram_addr [ADDR_W], sram_din/sram_dout [DATA_W]
`timescale 1ns/1ps
interface sram_req_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
);
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [1:0]          req_we;
   logic [2*ADDR_W-1:0] req_addr;
   logic [2*DATA_W-1:0] req_wdata;
   logic [1:0]          rsp_valid;
   logic [DATA_W-1:0]   rsp_rdata;
   logic                sram_wen;
   logic                sram_sense_en;
   logic [ADDR_W-1:0]   sram_addr;
   logic [DATA_W-1:0]   sram_din;
   logic [DATA_W-1:0]   sram_dout;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, sram_dout,
      input  req_ready, rsp_valid, rsp_rdata,
      input  sram_wen, sram_sense_en, sram_addr, sram_din
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, sram_dout,
      output req_ready, rsp_valid, rsp_rdata,
      output sram_wen, sram_sense_en, sram_addr, sram_din
   );
endinterface

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - round-robin two-requester sequencer for a single-port SRAM macro
//
// Purpose: accepts one operation at a time from two requesters (round-robin),
// drives registered SRAM strobes for exactly one cycle, waits out the SRAM
// read latency and returns a one-cycle completion pulse (with read data) to
// the requester that issued the operation.
// Ports:
//   clk            - clock, all state on posedge
//   rst            - asynchronous active-high reset
//   bus            - sram_req_arbiter_if.slave (requests, responses, SRAM pins)
//   stat_rd_cnt    - completed reads, saturating   (only with SRAM_REQ_ARBITER_STATS_EN)
//   stat_wr_cnt    - completed writes, saturating  (only with SRAM_REQ_ARBITER_STATS_EN)
// Optional feature macro: SRAM_REQ_ARBITER_STATS_EN
`timescale 1ns/1ps
module sram_req_arbiter #(
   parameter int SRAM_LATENCY = 1,
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 8
) (
   input  logic                clk,
   input  logic                rst,
   sram_req_arbiter_if.slave   bus
`ifdef SRAM_REQ_ARBITER_STATS_EN
   ,
   output logic [15:0]         stat_rd_cnt,
   output logic [15:0]         stat_wr_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t            state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              we_q, we_d;
   logic              last_gnt_q, last_gnt_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              sram_wen_q, sram_wen_d;
   logic              sram_sense_en_q, sram_sense_en_d;
   logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
   logic [DATA_W-1:0] sram_din_q, sram_din_d;
   logic [1:0]        rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

   logic              gnt_sel;
   logic [1:0]        req_ready_c;
   logic              accept;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [1:0]        gnt_onehot;

   // Arbitration: a lone requester wins; when both are valid the one that
   // did not win last time gets the grant.  Ready is forced low during reset
   // so every output reads 0 while rst is high.
   always_comb begin
      gnt_sel     = (&bus.req_valid) ? ~last_gnt_q : bus.req_valid[1];
      req_ready_c = 2'b00;
      if (state_q == ST_IDLE && !rst && (|bus.req_valid)) begin
         req_ready_c = gnt_sel ? 2'b10 : 2'b01;
      end
      accept     = |(req_ready_c & bus.req_valid);
      sel_we     = gnt_sel ? bus.req_we[1] : bus.req_we[0];
      sel_addr   = gnt_sel ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
      sel_wdata  = gnt_sel ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
      gnt_onehot = gnt_q ? 2'b10 : 2'b01;
   end

   always_comb begin
      state_d         = state_q;
      gnt_d           = gnt_q;
      we_d            = we_q;
      last_gnt_d      = last_gnt_q;
      cnt_d           = cnt_q;
      sram_wen_d      = 1'b0;
      sram_sense_en_d = 1'b0;
      sram_addr_d     = sram_addr_q;
      sram_din_d      = sram_din_q;
      rsp_valid_d     = 2'b00;
      rsp_rdata_d     = rsp_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               gnt_d           = gnt_sel;
               we_d            = sel_we;
               last_gnt_d      = gnt_sel;
               // Strobes are loaded on the accept edge so they are high
               // exactly during the ISSUE cycle, straight from flops.
               sram_addr_d     = sel_addr;
               sram_wen_d      = sel_we;
               sram_sense_en_d = ~sel_we;
               if (sel_we) begin
                  sram_din_d = sel_wdata;
               end
               state_d         = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (we_q) begin
               rsp_valid_d = gnt_onehot;
               state_d     = ST_RESP;
            end else begin
               cnt_d   = 4'(SRAM_LATENCY);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            // Count 1 marks the edge at which dout has been valid for
            // SRAM_LATENCY cycles after the sense edge.
            if (cnt_q == 4'd1) begin
               rsp_rdata_d = bus.sram_dout;
               rsp_valid_d = gnt_onehot;
               cnt_d       = 4'd0;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         gnt_q           <= 1'b0;
         we_q            <= 1'b0;
         last_gnt_q      <= 1'b1;
         cnt_q           <= 4'd0;
         sram_wen_q      <= 1'b0;
         sram_sense_en_q <= 1'b0;
         sram_addr_q     <= '0;
         sram_din_q      <= '0;
         rsp_valid_q     <= 2'b00;
         rsp_rdata_q     <= '0;
      end else begin
         state_q         <= state_d;
         gnt_q           <= gnt_d;
         we_q            <= we_d;
         last_gnt_q      <= last_gnt_d;
         cnt_q           <= cnt_d;
         sram_wen_q      <= sram_wen_d;
         sram_sense_en_q <= sram_sense_en_d;
         sram_addr_q     <= sram_addr_d;
         sram_din_q      <= sram_din_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_rdata_q     <= rsp_rdata_d;
      end
   end

`ifdef SRAM_REQ_ARBITER_STATS_EN
   logic [15:0] stat_rd_cnt_q, stat_rd_cnt_d;
   logic [15:0] stat_wr_cnt_q, stat_wr_cnt_d;

   // Counters step on entry to RESP so the new value is visible in the
   // same cycle as the completion pulse.
   always_comb begin
      stat_rd_cnt_d = stat_rd_cnt_q;
      stat_wr_cnt_d = stat_wr_cnt_q;
      if (|rsp_valid_d) begin
         if (we_q) begin
            if (stat_wr_cnt_q != 16'hFFFF) stat_wr_cnt_d = stat_wr_cnt_q + 16'd1;
         end else begin
            if (stat_rd_cnt_q != 16'hFFFF) stat_rd_cnt_d = stat_rd_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_rd_cnt_q <= 16'd0;
         stat_wr_cnt_q <= 16'd0;
      end else begin
         stat_rd_cnt_q <= stat_rd_cnt_d;
         stat_wr_cnt_q <= stat_wr_cnt_d;
      end
   end

   assign stat_rd_cnt = stat_rd_cnt_q;
   assign stat_wr_cnt = stat_wr_cnt_q;
`endif

   assign bus.req_ready     = req_ready_c;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_rdata     = rsp_rdata_q;
   assign bus.sram_wen      = sram_wen_q;
   assign bus.sram_sense_en = sram_sense_en_q;
   assign bus.sram_addr     = sram_addr_q;
   assign bus.sram_din      = sram_din_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - self-checking bench for sram_req_arbiter (latency 1 and 3 instances)
`timescale 1ns/1ps
module tb_sram_req_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0] who;
      logic [7:0] data;
      int         due;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];

   logic [1:0]  t_valid [2];
   logic [1:0]  t_we    [2];
   logic [19:0] t_addr  [2];
   logic [15:0] t_wdata [2];

   logic [1:0]  o_ready     [2];
   logic [1:0]  o_rsp_valid [2];
   logic [7:0]  o_rdata     [2];
   logic        o_wen       [2];
   logic        o_sense     [2];
   logic [9:0]  o_addr      [2];
   logic [7:0]  o_din       [2];
   logic [15:0] o_rd_cnt    [2];
   logic [15:0] o_wr_cnt    [2];

   logic [7:0] model_mem [2][1024];
   logic [7:0] last_rd   [2];
   logic       last_gnt  [2];
   int         n_rd      [2];
   int         n_wr      [2];

   for (genvar k = 0; k < 2; k++) begin : g_dut
      localparam int LAT = (k == 0) ? 1 : 3;
      sram_req_arbiter_if #(.ADDR_W(10), .DATA_W(8)) bus ();
      logic [7:0] mem  [1024];
      logic [7:0] pipe [LAT];

      initial for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

      assign bus.req_valid = t_valid[k];
      assign bus.req_we    = t_we[k];
      assign bus.req_addr  = t_addr[k];
      assign bus.req_wdata = t_wdata[k];
      assign bus.sram_dout = pipe[LAT-1];
      assign o_ready[k]     = bus.req_ready;
      assign o_rsp_valid[k] = bus.rsp_valid;
      assign o_rdata[k]     = bus.rsp_rdata;
      assign o_wen[k]       = bus.sram_wen;
      assign o_sense[k]     = bus.sram_sense_en;
      assign o_addr[k]      = bus.sram_addr;
      assign o_din[k]       = bus.sram_din;

      // SRAM macro: data sensed at the sense edge appears on dout LAT-1 edges later
      always @(posedge clk) begin
         if (bus.sram_wen) mem[bus.sram_addr] <= bus.sram_din;
         if (bus.sram_sense_en) pipe[0] <= mem[bus.sram_addr];
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end

`ifdef SRAM_REQ_ARBITER_STATS_EN
      logic [15:0] rd_cnt, wr_cnt;
      sram_req_arbiter #(.SRAM_LATENCY(LAT), .ADDR_W(10), .DATA_W(8)) dut (
         .clk(clk), .rst(rst), .bus(bus), .stat_rd_cnt(rd_cnt), .stat_wr_cnt(wr_cnt));
      assign o_rd_cnt[k] = rd_cnt;
      assign o_wr_cnt[k] = wr_cnt;
`else
      sram_req_arbiter #(.SRAM_LATENCY(LAT), .ADDR_W(10), .DATA_W(8)) dut (
         .clk(clk), .rst(rst), .bus(bus));
      assign o_rd_cnt[k] = 16'd0;
      assign o_wr_cnt[k] = 16'd0;
`endif
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   function automatic int qsize(input int k);
      return (k == 0) ? sb0.size() : sb1.size();
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic mon(input int k);
      exp_t e;
      if (o_rsp_valid[k] != 2'b00) begin
         if (qsize(k) == 0) begin
            chk($sformatf("unexpected_rsp_d%0d", k), 32'(o_rsp_valid[k]), 32'd0);
         end else begin
            if (k == 0) e = sb0.pop_front(); else e = sb1.pop_front();
            chk($sformatf("rsp_owner_d%0d", k), 32'(o_rsp_valid[k]), 32'(e.who));
            chk($sformatf("rsp_cycle_d%0d", k), 32'(cyc), 32'(e.due));
            chk($sformatf("rsp_rdata_d%0d", k), 32'(o_rdata[k]), 32'(e.data));
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   task automatic push(input int k, input int r, input logic we, input logic [9:0] addr,
                       input logic [7:0] wdata, input int acc);
      exp_t e;
      e.who = (r == 1) ? 2'b10 : 2'b01;
      if (we) begin
         model_mem[k][addr] = wdata;
         e.data = last_rd[k];
         e.due  = acc + 2;
         n_wr[k]++;
      end else begin
         e.data     = model_mem[k][addr];
         last_rd[k] = e.data;
         e.due      = acc + lat_of(k) + 2;
         n_rd[k]++;
      end
      last_gnt[k] = (r == 1);
      if (k == 0) sb0.push_back(e); else sb1.push_back(e);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         last_rd[k]  = 8'h00;
         last_gnt[k] = 1'b1;
         n_rd[k]     = 0;
         n_wr[k]     = 0;
      end
      sb0.delete();
      sb1.delete();
   endtask

   task automatic chk_zero(input int k);
      chk($sformatf("rst_ready_d%0d", k), 32'(o_ready[k]), 32'd0);
      chk($sformatf("rst_rsp_valid_d%0d", k), 32'(o_rsp_valid[k]), 32'd0);
      chk($sformatf("rst_rdata_d%0d", k), 32'(o_rdata[k]), 32'd0);
      chk($sformatf("rst_wen_d%0d", k), 32'(o_wen[k]), 32'd0);
      chk($sformatf("rst_sense_d%0d", k), 32'(o_sense[k]), 32'd0);
      chk($sformatf("rst_addr_d%0d", k), 32'(o_addr[k]), 32'd0);
      chk($sformatf("rst_din_d%0d", k), 32'(o_din[k]), 32'd0);
`ifdef SRAM_REQ_ARBITER_STATS_EN
      chk($sformatf("rst_stat_rd_d%0d", k), 32'(o_rd_cnt[k]), 32'd0);
      chk($sformatf("rst_stat_wr_d%0d", k), 32'(o_wr_cnt[k]), 32'd0);
`endif
   endtask

   task automatic drain(input int k);
      int n = 0;
      while (qsize(k) != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("drain_d%0d", k), 32'(qsize(k)), 32'd0);
      @(negedge clk);
   endtask

   // Called at a negedge with the DUT idle; returns at a later negedge, idle again.
   task automatic do_op(input int k, input int r, input logic we, input logic [9:0] addr,
                        input logic [7:0] wdata);
      logic [1:0] oh;
      oh = (r == 1) ? 2'b10 : 2'b01;
      t_we[k][r]          = we;
      t_addr[k][r*10 +: 10] = addr;
      t_wdata[k][r*8 +: 8]  = wdata;
      t_valid[k]          = oh;
      #1;
      chk($sformatf("ready_single_d%0d", k), 32'(o_ready[k]), 32'(oh));
      push(k, r, we, addr, wdata, cyc);
      @(posedge clk);
      @(negedge clk);
      t_valid[k] = 2'b00;
      #1;
      chk($sformatf("issue_wen_d%0d", k), 32'(o_wen[k]), 32'(we));
      chk($sformatf("issue_sense_d%0d", k), 32'(o_sense[k]), 32'(!we));
      chk($sformatf("issue_addr_d%0d", k), 32'(o_addr[k]), 32'(addr));
      if (we) chk($sformatf("issue_din_d%0d", k), 32'(o_din[k]), 32'(wdata));
      chk($sformatf("busy_ready_d%0d", k), 32'(o_ready[k]), 32'd0);
      @(negedge clk);
      #1;
      chk($sformatf("strobe_pulse_d%0d", k), 32'({o_wen[k], o_sense[k]}), 32'd0);
      drain(k);
   endtask

   // Both requesters held valid: requester 0 writes 10'h0F0, requester 1 reads 10'h155.
   task automatic alternate(input int k);
      int r;
      logic [1:0] want;
      t_we[k]    = 2'b01;
      t_addr[k]  = {10'h155, 10'h0F0};
      t_wdata[k] = {8'h00, 8'hC3};
      t_valid[k] = 2'b11;
      for (int i = 0; i < 6; i++) begin
         int n = 0;
         #1;
         while (o_ready[k] == 2'b00 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
         end
         chk($sformatf("alt_onehot_d%0d_%0d", k, i), 32'($onehot(o_ready[k])), 32'd1);
         r    = last_gnt[k] ? 0 : 1;
         want = (r == 1) ? 2'b10 : 2'b01;
         chk($sformatf("alt_grant_d%0d_%0d", k, i), 32'(o_ready[k]), 32'(want));
         if (r == 1) push(k, 1, 1'b0, 10'h155, 8'h00, cyc);
         else        push(k, 0, 1'b1, 10'h0F0, 8'hC3, cyc);
         @(negedge clk);
      end
      t_valid[k] = 2'b00;
      drain(k);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed_time=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         t_valid[k] = 2'b00;
         t_we[k]    = 2'b00;
         t_addr[k]  = 20'd0;
         t_wdata[k] = 16'd0;
         for (int a = 0; a < 1024; a++) model_mem[k][a] = 8'h00;
      end
      model_reset();
      #3;
      for (int k = 0; k < 2; k++) chk_zero(k);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 2; k++) begin
         do_op(k, 0, 1'b1, 10'h155, 8'hA5);
         do_op(k, 1, 1'b0, 10'h155, 8'h00);
         do_op(k, 0, 1'b1, 10'h3FF, 8'h5A);
         do_op(k, 1, 1'b1, 10'h000, 8'hFF);
         do_op(k, 0, 1'b0, 10'h3FF, 8'h00);
         do_op(k, 1, 1'b0, 10'h000, 8'h00);
         alternate(k);
      end

      // Reset in the middle of a latency-3 read: the op must vanish.
      t_we[1][1]      = 1'b0;
      t_addr[1][19:10] = 10'h155;
      t_valid[1]      = 2'b10;
      @(posedge clk);
      @(negedge clk);
      t_valid[1] = 2'b00;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      for (int k = 0; k < 2; k++) chk_zero(k);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      do_op(1, 1, 1'b0, 10'h155, 8'h00);
      do_op(0, 0, 1'b0, 10'h3FF, 8'h00);
      do_op(1, 0, 1'b1, 10'h200, 8'h11);
      do_op(1, 1, 1'b0, 10'h200, 8'h00);

      drain(0);
      drain(1);
`ifdef SRAM_REQ_ARBITER_STATS_EN
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("stat_rd_d%0d", k), 32'(o_rd_cnt[k]), 32'(n_rd[k]));
         chk($sformatf("stat_wr_d%0d", k), 32'(o_wr_cnt[k]), 32'(n_wr[k]));
      end
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
